// File: rtl/calc_pkg.sv
// Shared types, LCD command bytes and helpers for the calculator framework.
package calc_pkg;

  typedef enum logic [2:0] {
    S_POWERON,
    S_INIT,
    S_BANNER,
    S_WRITE,
    S_IDLE
  } state_t;

  // Sub-phases of a single LCD byte write.
  typedef enum logic [2:0] {
    PH_READY,
    PH_SETUP,
    PH_PULSE,
    PH_HOLD,
    PH_WAIT
  } phase_t;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_LINE1    = 8'h80;
  localparam logic [7:0] LCD_LINE2    = 8'hC0;

  // 0-9 map to '0'-'9'; 10-15 map to 'A'-'F' (0x41 + n - 10 == 0x37 + n).
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n <= 4'd9) return 8'h30 + {4'h0, n};
    return 8'h37 + {4'h0, n};
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/calc_top_debounce.sv
// Push-button conditioner: 2-FF synchronizer followed by a stable-time filter.
// Output idles high (button released) and follows the input only after it holds steady.
module debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLOCK_50,
  input  logic RESET,
  input  logic noisy_in,
  output logic clean_out
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_0;
  logic             sync_1;
  logic [CNT_W-1:0] cnt;

  // NOTE: clocked state uses <= so every register samples pre-edge values, independent of statement order.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sync_0    <= 1'b1;
      sync_1    <= 1'b1;
      cnt       <= '0;
      clean_out <= 1'b1;
    end else begin
      sync_0 <= noisy_in;
      sync_1 <= sync_0;
      // Any return to the current output level restarts the stability window.
      if (sync_1 == clean_out) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        clean_out <= sync_1;
        cnt       <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/calc_top.sv
// Calculator framework top: counts debounced button presses and shows the count as
// two hex digits on an HD44780 LCD. Define LCD_BANNER_EN to print "CALC" on line 2 once after init.
module calc_top
  import calc_pkg::*;
#(
  parameter int POWERON_CYCLES    = 750000,
  parameter int E_PULSE_CYCLES    = 12,
  parameter int SETUP_CYCLES      = 2,
  parameter int CMD_WAIT_CYCLES   = 2500,
  parameter int CLEAR_WAIT_CYCLES = 82000,
  parameter int DEBOUNCE_CYCLES   = 500000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       BUTTON,
  output logic       RS,
  output logic       E,
  output logic [7:0] D,
  output logic [2:0] LED
);

  localparam int MAX_WAIT = max_int(max_int(POWERON_CYCLES, CLEAR_WAIT_CYCLES),
                                    max_int(max_int(CMD_WAIT_CYCLES, E_PULSE_CYCLES), SETUP_CYCLES));
  localparam int TIMER_W = $clog2(MAX_WAIT + 1);

  localparam logic [TIMER_W-1:0] T_POWERON = TIMER_W'(POWERON_CYCLES - 1);
  localparam logic [TIMER_W-1:0] T_SETUP   = TIMER_W'(SETUP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] T_PULSE   = TIMER_W'(E_PULSE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] T_CMD     = TIMER_W'(CMD_WAIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] T_CLEAR   = TIMER_W'(CLEAR_WAIT_CYCLES - 1);

  logic               clean_signal;
  logic               prev_clean;
  logic               press;
  logic [7:0]         count;
  logic [7:0]         count_next;
  logic               pending;

  state_t             state;
  phase_t             phase;
  logic [2:0]         step;
  logic [TIMER_W-1:0] timer;
  logic               long_wait;
  logic [7:0]         snapshot;

  logic [7:0]         cur_byte;
  logic               cur_rs;
  logic               cur_last;

  debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .noisy_in (BUTTON),
    .clean_out(clean_signal)
  );

  // Button is active-low, so a press is the falling edge of the debounced level.
  assign press      = prev_clean & ~clean_signal;
  assign count_next = count + {7'd0, press};

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      prev_clean <= 1'b1;
      count      <= '0;
      LED        <= '0;
    end else begin
      prev_clean <= clean_signal;
      count      <= count_next;
      LED        <= count_next[2:0];
    end
  end

  // Byte table: what the current state sends at each step, and whether it is the last one.
  // NOTE: every output gets a default first so no path through the case can infer a latch.
  always_comb begin
    cur_byte = LCD_FUNC_SET;
    cur_rs   = 1'b0;
    cur_last = 1'b0;
    unique case (state)
      S_INIT: begin
        unique case (step)
          3'd0:    cur_byte = LCD_FUNC_SET;
          3'd1:    cur_byte = LCD_DISP_ON;
          3'd2:    cur_byte = LCD_CLEAR;
          default: begin
            cur_byte = LCD_ENTRY;
            cur_last = 1'b1;
          end
        endcase
      end
`ifdef LCD_BANNER_EN
      S_BANNER: begin
        cur_rs = (step != 3'd0);
        unique case (step)
          3'd0:    cur_byte = LCD_LINE2;
          3'd1:    cur_byte = 8'h43;
          3'd2:    cur_byte = 8'h41;
          3'd3:    cur_byte = 8'h4C;
          default: begin
            cur_byte = 8'h43;
            cur_last = 1'b1;
          end
        endcase
      end
`endif
      S_WRITE: begin
        unique case (step)
          3'd0:    cur_byte = LCD_LINE1;
          3'd1:    begin
            cur_byte = hex_ascii(snapshot[7:4]);
            cur_rs   = 1'b1;
          end
          default: begin
            cur_byte = hex_ascii(snapshot[3:0]);
            cur_rs   = 1'b1;
            cur_last = 1'b1;
          end
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state     <= S_POWERON;
      phase     <= PH_READY;
      step      <= '0;
      timer     <= '0;
      long_wait <= 1'b0;
      snapshot  <= '0;
      pending   <= 1'b0;
      RS        <= 1'b0;
      E         <= 1'b0;
      D         <= '0;
    end else begin
      unique case (phase)
        PH_READY: begin
          unique case (state)
            S_POWERON: begin
              if (timer == T_POWERON) begin
                state <= S_INIT;
                step  <= '0;
                timer <= '0;
              end else begin
                timer <= timer + TIMER_W'(1);
              end
            end
            S_IDLE: begin
              if (pending) begin
                pending  <= 1'b0;
                snapshot <= count;
                step     <= '0;
                state    <= S_WRITE;
              end
            end
            default: begin
              RS        <= cur_rs;
              D         <= cur_byte;
              long_wait <= !cur_rs && (cur_byte == LCD_CLEAR);
              timer     <= '0;
              phase     <= PH_SETUP;
            end
          endcase
        end
        PH_SETUP: begin
          if (timer == T_SETUP) begin
            E     <= 1'b1;
            timer <= '0;
            phase <= PH_PULSE;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        PH_PULSE: begin
          if (timer == T_PULSE) begin
            E     <= 1'b0;
            phase <= PH_HOLD;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        // RS/D stay put for one clock after E falls, then the execution wait starts.
        PH_HOLD: begin
          timer <= '0;
          phase <= PH_WAIT;
        end
        PH_WAIT: begin
          if (timer == (long_wait ? T_CLEAR : T_CMD)) begin
            timer <= '0;
            phase <= PH_READY;
            if (!cur_last) begin
              step <= step + 3'd1;
            end else begin
              step <= '0;
              unique case (state)
`ifdef LCD_BANNER_EN
                S_INIT:   state <= S_BANNER;
                S_BANNER: begin
                  state    <= S_WRITE;
                  snapshot <= count;
                end
`else
                S_INIT: begin
                  state    <= S_WRITE;
                  snapshot <= count;
                end
`endif
                default:  state <= S_IDLE;
              endcase
            end
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        default: phase <= PH_READY;
      endcase
      // Placed last so a new press beats the clear when S_IDLE consumes pending.
      if (press) pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_calc_top.sv
// Directed bench for calc_top with shortened timing; a negedge monitor records every E strobe.
// Define LCD_BANNER_EN for both RTL and bench to expect the "CALC" banner.
module tb_calc_top;

  localparam int POWERON    = 20;
  localparam int E_PULSE    = 12;
  localparam int SETUP      = 2;
  localparam int CMD_WAIT   = 10;
  localparam int CLEAR_WAIT = 30;
  localparam int DEBOUNCE   = 4;

  logic       clk = 1'b0;
  logic       RESET;
  logic       BUTTON;
  logic       RS;
  logic       E;
  logic [7:0] D;
  logic [2:0] LED;

  int compared   = 0;
  int mismatched = 0;

  always #10 clk = ~clk;

  calc_top #(
    .POWERON_CYCLES   (POWERON),
    .E_PULSE_CYCLES   (E_PULSE),
    .SETUP_CYCLES     (SETUP),
    .CMD_WAIT_CYCLES  (CMD_WAIT),
    .CLEAR_WAIT_CYCLES(CLEAR_WAIT),
    .DEBOUNCE_CYCLES  (DEBOUNCE)
  ) dut (
    .CLOCK_50(clk),
    .RESET   (RESET),
    .BUTTON  (BUTTON),
    .RS      (RS),
    .E       (E),
    .D       (D),
    .LED     (LED)
  );

  // Strobe monitor: per E pulse it records byte, RS, setup samples, low gap before it,
  // the gap the previous byte demands, high width and whether RS/D held through the fall.
  logic [7:0] mon_d[$];
  logic       mon_rs[$];
  int         mon_gap[$];
  int         mon_req[$];
  int         mon_setup[$];
  int         mon_width[$];
  logic       mon_held[$];

  logic       e_q;
  logic [8:0] rsd_q;
  logic [8:0] rsd_rise;
  logic       held_bad;
  logic       first_after_rst;
  logic       prev_clear;
  int         hi_cnt;
  int         lo_cnt;
  int         same_cnt;

  always @(negedge clk) begin
    if (RESET) begin
      e_q             = 1'b0;
      rsd_q           = '0;
      held_bad        = 1'b0;
      first_after_rst = 1'b1;
      prev_clear      = 1'b0;
      hi_cnt          = 0;
      lo_cnt          = 0;
      same_cnt        = 0;
    end else begin
      if ({RS, D} == rsd_q) same_cnt++;
      else same_cnt = 0;
      rsd_q = {RS, D};
      if (E && !e_q) begin
        mon_d.push_back(D);
        mon_rs.push_back(RS);
        mon_gap.push_back(lo_cnt);
        mon_req.push_back(first_after_rst ? POWERON : (prev_clear ? CLEAR_WAIT : CMD_WAIT));
        mon_setup.push_back(same_cnt);
        first_after_rst = 1'b0;
        prev_clear      = !RS && (D == 8'h01);
        rsd_rise        = {RS, D};
        held_bad        = 1'b0;
        hi_cnt          = 1;
      end else if (E) begin
        hi_cnt++;
        if ({RS, D} != rsd_rise) held_bad = 1'b1;
      end else if (e_q) begin
        if ({RS, D} != rsd_rise) held_bad = 1'b1;
        mon_width.push_back(hi_cnt);
        mon_held.push_back(!held_bad);
        lo_cnt = 1;
      end else begin
        lo_cnt++;
      end
      e_q = E;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_strobe(input string tag, input logic [7:0] d_exp, input logic rs_exp);
    int n;
    n = 0;
    while (mon_width.size() == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_seen"}, mon_width.size() != 0, 1'b1);
    if (mon_width.size() != 0 && mon_d.size() != 0) begin
      int gap;
      int req;
      check({tag, "_d"}, mon_d.pop_front(), d_exp);
      check({tag, "_rs"}, mon_rs.pop_front(), rs_exp);
      check({tag, "_width"}, mon_width.pop_front(), E_PULSE);
      check({tag, "_setup_ok"}, mon_setup.pop_front() >= SETUP, 1'b1);
      check({tag, "_held"}, mon_held.pop_front(), 1'b1);
      gap = mon_gap.pop_front();
      req = mon_req.pop_front();
      check($sformatf("%s_gap_%0d_vs_%0d", tag, gap, req), gap >= req, 1'b1);
    end
  endtask

  task automatic expect_init(input string tag);
    expect_strobe({tag, "_func"},  8'h38, 1'b0);
    expect_strobe({tag, "_disp"},  8'h0C, 1'b0);
    expect_strobe({tag, "_clear"}, 8'h01, 1'b0);
    expect_strobe({tag, "_entry"}, 8'h06, 1'b0);
`ifdef LCD_BANNER_EN
    expect_strobe({tag, "_line2"}, 8'hC0, 1'b0);
    expect_strobe({tag, "_ban_c"}, 8'h43, 1'b1);
    expect_strobe({tag, "_ban_a"}, 8'h41, 1'b1);
    expect_strobe({tag, "_ban_l"}, 8'h4C, 1'b1);
    expect_strobe({tag, "_ban_c2"}, 8'h43, 1'b1);
`endif
  endtask

  task automatic clear_monitor();
    mon_d.delete();
    mon_rs.delete();
    mon_gap.delete();
    mon_req.delete();
    mon_setup.delete();
    mon_width.delete();
    mon_held.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  flag;

    // Reset and power-on quiet period.
    RESET  = 1'b1;
    BUTTON = 1'b1;
    repeat (4) @(negedge clk);
    RESET = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rs", RS, 1'b0);
    check("rst_e", E, 1'b0);
    check("rst_d", D, 8'h00);
    check("rst_led", LED, 3'b000);
    check("rst_clean", dut.clean_signal, 1'b1);
    flag = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (E || RS || D != 8'h00) flag = 1'b1;
    end
    check("poweron_quiet", flag, 1'b0);

    // Init sequence and the first display of "00".
    expect_init("boot");
    expect_strobe("boot_line1", 8'h80, 1'b0);
    expect_strobe("boot_hi", 8'h30, 1'b1);
    expect_strobe("boot_lo", 8'h30, 1'b1);

    // Forced press in S_IDLE.
    repeat (40) @(negedge clk);
    force dut.clean_signal = 1'b0;
    @(negedge clk);
    check("press1_led", LED, 3'b001);
    expect_strobe("press1_line1", 8'h80, 1'b0);
    expect_strobe("press1_hi", 8'h30, 1'b1);
    expect_strobe("press1_lo", 8'h31, 1'b1);
    release dut.clean_signal;
    repeat (40) @(negedge clk);

    // Two-clock BUTTON glitch must be filtered out.
    BUTTON = 1'b0;
    repeat (2) @(negedge clk);
    BUTTON = 1'b1;
    flag = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (dut.clean_signal !== 1'b1) flag = 1'b1;
    end
    check("glitch_clean", flag, 1'b0);
    check("glitch_led", LED, 3'b001);
    check("glitch_no_strobe", mon_d.size(), 0);

    // A real press through the debouncer.
    BUTTON = 1'b0;
    n = 0;
    while (dut.clean_signal !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("button_clean_low", dut.clean_signal, 1'b0);
    @(negedge clk);
    check("button_led", LED, 3'b010);
    expect_strobe("press2_line1", 8'h80, 1'b0);
    expect_strobe("press2_hi", 8'h30, 1'b1);
    expect_strobe("press2_lo", 8'h32, 1'b1);
    BUTTON = 1'b1;
    n = 0;
    while (dut.clean_signal !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("button_clean_high", dut.clean_signal, 1'b1);
    repeat (40) @(negedge clk);

    // Reset while E is high.
    force dut.clean_signal = 1'b0;
    n = 0;
    while (E !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("midwrite_e_high", E, 1'b1);
    RESET = 1'b1;
    @(negedge clk);
    check("midwrite_e_drop", E, 1'b0);
    check("midwrite_led", LED, 3'b000);
    release dut.clean_signal;
    repeat (3) @(negedge clk);
    clear_monitor();
    RESET = 1'b0;
    @(negedge clk);
    check("rerst_rs", RS, 1'b0);
    check("rerst_d", D, 8'h00);
    check("rerst_clean", dut.clean_signal, 1'b1);

    // Ten presses during init: one queued refresh after the init-time write.
    n = 0;
    while (mon_d.size() == 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("rerun_first_strobe", mon_d.size() != 0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      force dut.clean_signal = 1'b0;
      @(negedge clk);
      force dut.clean_signal = 1'b1;
      @(negedge clk);
    end
    release dut.clean_signal;
    @(negedge clk);
    check("toggle_led", LED, 3'b010);
    expect_init("rerun");
    expect_strobe("rerun_line1", 8'h80, 1'b0);
    expect_strobe("rerun_hi", 8'h30, 1'b1);
    expect_strobe("rerun_lo", 8'h41, 1'b1);
    expect_strobe("refresh_line1", 8'h80, 1'b0);
    expect_strobe("refresh_hi", 8'h30, 1'b1);
    expect_strobe("refresh_lo", 8'h41, 1'b1);
    repeat (300) @(negedge clk);
    check("single_refresh", mon_d.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
